// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the sequential shift-add multiplier.
//   N      : operand width. The ripple-carry adder is built for 8 bits.
//   CNT_W  : iteration counter width, $clog2(N).
//   P_W    : product width, 2*N.
//   mult_state_t : controller states.
//   gate_mcand() : selects the partial product for one iteration.
// -----------------------------------------------------------------------------
package mult_pkg;

    localparam int N     = 8;
    localparam int CNT_W = $clog2(N);
    localparam int P_W   = 2 * N;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } mult_state_t;

    // Partial product for one iteration: the multiplicand when the current
    // multiplier bit is set, otherwise zero.
    function automatic logic [N-1:0] gate_mcand(input logic         bit_sel,
                                                input logic [N-1:0] mcand);
        return bit_sel ? mcand : '0;
    endfunction

endpackage

// File: rtl/shift_add_mult8_rca.sv
// -----------------------------------------------------------------------------
// RCAmanual
// 8-bit ripple-carry adder built from explicit full-adder cells.
// Ports:
//   x   [7:0] in  : first addend
//   y   [7:0] in  : second addend
//   sum [8:0] out : x + y, sum[8] is the carry out
// Purely combinational.
// -----------------------------------------------------------------------------
module RCAmanual
    import mult_pkg::*;
(
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N:0]   sum
);

    // carry[gi] is the carry into bit gi; carry[N] is the carry out.
    logic [N:0] carry;

    assign carry[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_fa
            logic p_bit;
            logic g_bit;

            assign p_bit          = x[gi] ^ y[gi];
            assign g_bit          = x[gi] & y[gi];
            assign sum[gi]        = p_bit ^ carry[gi];
            assign carry[gi + 1]  = g_bit | (p_bit & carry[gi]);
        end
    endgenerate

    assign sum[N] = carry[N];

endmodule

// File: rtl/shift_add_mult8.sv
// -----------------------------------------------------------------------------
// shift_add_mult8
// Sequential 8x8 unsigned multiplier. One partial-product add per clock through
// a single 8-bit ripple-carry adder; the 16-bit product is ready after 8
// iterations.
// Ports:
//   clk        in   1  : clock, all state updates on posedge
//   reset      in   1  : synchronous, active-high
//   in_valid   in   1  : a/b valid
//   in_ready   out  1  : operands can be accepted (IDLE only)
//   a          in   8  : multiplicand, unsigned
//   b          in   8  : multiplier, unsigned
//   out_valid  out  1  : product valid (DONE only), registered
//   out_ready  in   1  : consumer accepts product
//   product    out  16 : a*b, registered, held until accepted
// Timing: accept edge, 8 RUN cycles, then out_valid. With out_ready held high
// a new product is delivered every 10 clocks.
// -----------------------------------------------------------------------------
module shift_add_mult8
    import mult_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [P_W-1:0] product
);

    mult_state_t    state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [N-1:0]   mcand_reg, mcand_next;
    logic [N-1:0]   hi_reg, hi_next;
    logic [N-1:0]   lo_reg, lo_next;
    logic [P_W-1:0] product_reg, product_next;
    logic           out_valid_reg, out_valid_next;

    logic [N-1:0]   add_y;
    logic [N:0]     add_sum;

    // hi is the running upper half; lo holds the unconsumed multiplier bits in
    // its low end and collects product bits shifted in at the top.
    assign add_y = gate_mcand(lo_reg[0], mcand_reg);

    RCAmanual u_rca (
        .x   (hi_reg),
        .y   (add_y),
        .sum (add_sum)
    );

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        mcand_next     = mcand_reg;
        hi_next        = hi_reg;
        lo_next        = lo_reg;
        product_next   = product_reg;
        out_valid_next = out_valid_reg;

        case (state_reg)
            S_IDLE: begin
                if (in_valid) begin
                    mcand_next = a;
                    lo_next    = b;
                    hi_next    = '0;
                    cnt_next   = '0;
                    state_next = S_RUN;
                end
            end

            S_RUN: begin
                // Shifting the 9-bit sum right by one keeps the carry in
                // hi[7]; the dropped bit becomes the next product bit in lo.
                hi_next  = add_sum[N:1];
                lo_next  = {add_sum[0], lo_reg[N-1:1]};
                cnt_next = cnt_reg + CNT_W'(1);   // wraps to 0 on the last pass
                if (cnt_reg == CNT_W'(N - 1)) begin
                    // Capture the final {hi,lo} straight into the output
                    // register so product and out_valid rise together.
                    state_next     = S_DONE;
                    out_valid_next = 1'b1;
                    product_next   = {add_sum[N:1], add_sum[0], lo_reg[N-1:1]};
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    state_next     = S_IDLE;
                    out_valid_next = 1'b0;
                end
            end

            default: begin
                state_next     = S_IDLE;
                out_valid_next = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            mcand_reg     <= '0;
            hi_reg        <= '0;
            lo_reg        <= '0;
            product_reg   <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            mcand_reg     <= mcand_next;
            hi_reg        <= hi_next;
            lo_reg        <= lo_next;
            product_reg   <= product_next;
            out_valid_reg <= out_valid_next;
        end
    end

    // in_ready decodes the state register only, so it is low whenever
    // out_valid is high.
    assign in_ready  = (state_reg == S_IDLE);
    assign out_valid = out_valid_reg;
    assign product   = product_reg;

endmodule

// File: tb/tb_shift_add_mult8.sv
// -----------------------------------------------------------------------------
// tb_shift_add_mult8
// Self-checking bench for shift_add_mult8. Expected products come from plain
// integer multiplication; timing expectations come from the handshake rules
// (accept-to-out_valid of 9 clocks, one product per 10 clocks when streaming).
// -----------------------------------------------------------------------------
module tb_shift_add_mult8;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;

    int n_cmp;
    int n_mis;

    shift_add_mult8 dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        int r;
        r = int'(x) * int'(y);
        return r[15:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One stand-alone transaction: accept, measure latency, optionally hold the
    // result for 'hold' cycles with out_ready low, then hand it off.
    task automatic run_one(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                           input int hold);
        int          w;
        int          lat;
        logic [15:0] exp_p;
        exp_p = ref_mul(ta, tb);
        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        a         = ta;
        b         = tb;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();                       // accept edge
        in_valid = 1'b0;
        a        = 8'($urandom);      // must not affect the result
        b        = 8'($urandom);
        lat      = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd9);
        check({tag, "_product"}, 32'(product), 32'(exp_p));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a        = 8'($urandom);
            b        = 8'($urandom);
            tick();
            check({tag, "_hold_ov"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_prod"}, 32'(product), 32'(exp_p));
            check({tag, "_hold_inrdy"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();                       // output handshake
        out_ready = 1'b0;
        check({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_idle"}, 32'(in_ready), 32'd1);
        $display("txn %s: a=%0d b=%0d product=0x%04h exp=0x%04h lat=%0d hold=%0d",
                 tag, ta, tb, product, exp_p, lat, hold);
    endtask

    // Streaming with in_valid and out_ready held high. A queue of model
    // products checks order, loss and duplication; optional period check.
    task automatic stream(input string tag, input int npairs, input bit chk_period);
        logic [15:0] q[$];
        logic [15:0] exp_p;
        int acc;
        int got;
        int cyc;
        int last_out;
        bit fin;
        bit fout;
        acc      = 0;
        got      = 0;
        cyc      = 0;
        last_out = -1;
        a         = 8'($urandom);
        b         = 8'($urandom);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (got < npairs && cyc < npairs * 12 + 20) begin
            fin  = in_valid && in_ready;
            fout = out_valid && out_ready;
            if (fout) begin
                if (q.size() == 0) begin
                    check({tag, "_unexpected_out"}, 32'(product), 32'hFFFF_FFFF);
                end else begin
                    exp_p = q.pop_front();
                    check({tag, "_product"}, 32'(product), 32'(exp_p));
                    $display("txn %s #%0d: product=0x%04h exp=0x%04h cycle=%0d",
                             tag, got, product, exp_p, cyc);
                end
                if (chk_period && last_out >= 0)
                    check({tag, "_period"}, 32'(cyc - last_out), 32'd10);
                last_out = cyc;
                got++;
            end
            if (fin) begin
                q.push_back(ref_mul(a, b));
                acc++;
            end
            tick();
            cyc++;
            if (fin) begin
                a = 8'($urandom);
                b = 8'($urandom);
                if (acc == npairs) in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check({tag, "_count"}, 32'(got), 32'(npairs));
        check({tag, "_leftover"}, 32'(q.size()), 32'd0);
        tick();
        tick();
    endtask

    initial begin
        int w;
        n_cmp     = 0;
        n_mis     = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        repeat (3) tick();

        // Reset state
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        reset = 1'b0;
        tick();

        // Directed cases
        run_one("d13x11", 8'd13, 8'd11, 0);
        run_one("ffxff", 8'hFF, 8'hFF, 0);
        run_one("abx00", 8'hAB, 8'h00, 0);
        run_one("00xab", 8'h00, 8'hAB, 0);
        run_one("backpressure", 8'hC7, 8'h9D, 5);

        // Reset in the 4th RUN cycle; product register still holds 0xC7*0x9D
        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        a        = 8'd200;
        b        = 8'd77;
        in_valid = 1'b1;
        tick();                       // accept
        in_valid = 1'b0;
        repeat (3) tick();            // RUN cycles 1..3
        reset = 1'b1;
        tick();
        check("midrun_rst_in_ready", 32'(in_ready), 32'd1);
        check("midrun_rst_out_valid", 32'(out_valid), 32'd0);
        check("midrun_rst_product", 32'(product), 32'd0);
        reset = 1'b0;
        tick();
        check("midrun_rst_stays_idle", 32'(out_valid), 32'd0);
        run_one("after_rst_3x5", 8'd3, 8'd5, 0);

        // Random stand-alone transactions with random backpressure
        for (int i = 0; i < 30; i++)
            run_one("rand", 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));

        // Back-to-back streaming
        stream("stream3", 3, 1'b1);
        stream("sweep", 400, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
